xadc_channel_scanner: RTL and testbench
=======================================

XADC_CHANNEL_SCANNER -- requirements
Module: xadc_channel_scanner

Interface
REQ-001 Parameter NUM_CH, default 13: number of scanned channels (1..13).
REQ-002 Parameter GAP_CYCLES, default 100: idle clk cycles between successive DRP reads (>=1).
REQ-003 Parameter TIMEOUT, default 255: max clk cycles waited for drdy_in per read.
REQ-004 clk  input  1  DRP/system clock (100 MHz domain).
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 scan_en  input  1  1 = scan continuously; 0 = stop at end of the current read.
REQ-007 daddr_out  output  7  DRP address of the current read.
REQ-008 den_out  output  1  DRP enable, single-cycle pulse per read.
REQ-009 do_in  input  16  DRP read data; result in bits [15:4].
REQ-010 drdy_in  input  1  DRP data-ready strobe.
REQ-011 rd_ch  input  4  read-port channel select.
REQ-012 rd_data  output  12  stored result for rd_ch.
REQ-013 ch_valid  output  13  bit i = channel i holds at least one good result.
REQ-014 scan_done  output  1  one-cycle pulse after the last channel of a pass is stored.
REQ-015 drp_err  output  1  sticky flag, set on any drdy timeout.

Function
REQ-016 Channel-to-address map: ch 0 -> 7'h03 (VP/VN); ch k (1..12) -> 7'h10 + k - 1 (VAUX0..VAUX11).
REQ-017 The FSM states are IDLE, GAP, REQ, WAIT, STORE.
REQ-018 IDLE -> GAP when scan_en=1; the gap counter loads GAP_CYCLES-1.
REQ-019 GAP -> REQ when the counter reaches 0.
REQ-020 REQ lasts one cycle: den_out=1, daddr_out=map(ch) -> WAIT.
REQ-021 daddr_out holds its value from REQ until leaving WAIT.
REQ-022 WAIT -> STORE on the first drdy_in=1 and captures do_in[15:4].
REQ-023 WAIT on a timeout (TIMEOUT cycles without drdy_in): set drp_err, leave the entry and its ch_valid bit unchanged, advance channel, -> GAP or IDLE.
REQ-024 STORE writes the result into entry ch and sets ch_valid[ch].
REQ-025 STORE advances ch (NUM_CH-1 wraps to 0) and then goes to GAP if scan_en=1, otherwise IDLE.
REQ-026 scan_done pulses in the cycle after the STORE or timeout of ch NUM_CH-1.
REQ-027 drdy_in while not in WAIT is ignored.
REQ-028 den_out is never asserted outside REQ.
REQ-029 Only one read is outstanding at a time.
REQ-030 rd_data is registered: it equals entry[rd_ch] one cycle after rd_ch is presented.
REQ-031 rd_ch >= NUM_CH gives rd_data=0.
REQ-032 A read of the entry being written in the same cycle returns the old value; the new value appears the next cycle.
REQ-033 ch_valid bits >= NUM_CH are always 0.
REQ-034 Deasserting scan_en during WAIT completes that read (or its timeout) before IDLE; no read is aborted.

Reset
REQ-035 rst takes effect on the clk edge where it is sampled high, in any state, including mid-read.
REQ-036 After reset: state=IDLE, ch=0, daddr_out=0, den_out=0, rd_data=0, ch_valid=0, scan_done=0, drp_err=0, all entries 0.
REQ-037 A drdy_in for a read aborted by reset is ignored.
REQ-038 drp_err clears only on rst.

Configuration
REQ-039 Macro XADC_SCAN_AVG_EN defined: each channel is read 4 consecutive times (each read preceded by GAP).
REQ-040 With XADC_SCAN_AVG_EN, the four 12-bit samples are summed in a 14-bit accumulator and STORE writes sum[13:2] after the 4th sample.
REQ-041 With XADC_SCAN_AVG_EN, a timeout on any of the 4 reads discards the partial sum, leaves the entry unchanged, sets drp_err and advances ch.
REQ-042 Macro XADC_SCAN_AVG_EN undefined: one read per channel and STORE writes do_in[15:4] directly; there is no accumulator logic.

Verification
REQ-043 Reset then scan_en=1 with a DRP model returning do_in=16'h8000 with drdy 3 cycles after den: first den_out exactly GAP_CYCLES cycles after scan_en, daddr_out=7'h03; the next read uses 7'h10.
REQ-044 A full pass of 13 channels with do_in=(ch<<8)<<4: scan_done pulses once; ch_valid=13'h1FFF; rd_ch=5 gives rd_data=12'h500 one cycle later.
REQ-045 The model withholds drdy for ch 3: drp_err=1 after TIMEOUT cycles; ch_valid[3]=0; the next den_out uses address 7'h13 (ch 4).
REQ-046 scan_en dropped during WAIT of ch 2: that result is stored; no further den_out; state IDLE.
REQ-047 rst asserted during WAIT, then a late drdy with 16'hFFF0: all outputs at their reset values; entry 0 stays 0.
REQ-048 With XADC_SCAN_AVG_EN, samples 12'h100, 12'h101, 12'h102, 12'h103 on ch 0: rd_data=12'h101 and 4 den pulses on 7'h03.

Source files
------------

// File: rtl/xadc_channel_scanner.sv
// Round-robin XADC DRP scanner: reads up to 13 channels, one read at a time, into a result table.
// Define XADC_SCAN_AVG_EN to store the average of four consecutive reads per channel.
module xadc_channel_scanner #(
  parameter int NUM_CH     = 13,
  parameter int GAP_CYCLES = 100,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  input  logic [3:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic [12:0] ch_valid,
  output logic        scan_done,
  output logic        drp_err,
  output logic [2:0]  state_dbg
);

  // DRP handshake: den_out is a one-cycle request with daddr_out valid in the same cycle;
  // the first drdy_in seen while waiting completes it, and drdy_in is ignored at all other times.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_gap_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [3:0]    r_ch;
  logic [6:0]    r_daddr;
  logic [11:0]   r_entry [16];
  logic [12:0]   r_valid;
  logic [11:0]   r_rd_data;
  logic          r_scan_done;
  logic          r_err;
  logic          w_den;
  logic          w_load_gap;
  logic          w_capture;
  logic          w_timeout;
  logic          w_store;
  logic          w_advance;
  logic [6:0]    w_map;
  logic [12:0]   w_ch_mask;
  logic [11:0]   w_result;
  logic          w_unused_lsbs;

`ifdef XADC_SCAN_AVG_EN
  logic [13:0]   r_acc;
  logic [1:0]    r_rep;
  assign w_result = r_acc[13:2];
`else
  logic [11:0]   r_sample;
  assign w_result = r_sample;
`endif

  assign w_map         = (r_ch == 4'd0) ? 7'h03 : 7'h0F + {3'b000, r_ch};
  assign w_ch_mask     = 13'd1 << r_ch;
  assign w_unused_lsbs = ^do_in[3:0];

  assign daddr_out = r_daddr;
  assign den_out   = w_den;
  assign rd_data   = r_rd_data;
  assign ch_valid  = r_valid;
  assign scan_done = r_scan_done;
  assign drp_err   = r_err;
  assign state_dbg = r_state;

  always_comb begin
    w_next     = r_state;
    w_den      = 1'b0;
    w_load_gap = 1'b0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    w_store    = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (scan_en) begin
          w_next     = ST_GAP;
          w_load_gap = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_next = ST_REQ;
      end
      ST_REQ: begin
        w_den  = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (drdy_in) begin
          w_capture = 1'b1;
`ifdef XADC_SCAN_AVG_EN
          // Samples 1..3 loop back through GAP; scan_en is only honoured per channel.
          if (r_rep == 2'd3) begin
            w_next = ST_STORE;
          end else begin
            w_next     = ST_GAP;
            w_load_gap = 1'b1;
          end
`else
          w_next = ST_STORE;
`endif
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_advance = 1'b1;
          if (scan_en) begin
            w_next     = ST_GAP;
            w_load_gap = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_STORE: begin
        w_store   = 1'b1;
        w_advance = 1'b1;
        if (scan_en) begin
          w_next     = ST_GAP;
          w_load_gap = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
      r_ch        <= '0;
      r_daddr     <= '0;
      r_valid     <= '0;
      r_rd_data   <= '0;
      r_scan_done <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < 16; i++) r_entry[i] <= '0;
`ifdef XADC_SCAN_AVG_EN
      r_acc       <= '0;
      r_rep       <= '0;
`else
      r_sample    <= '0;
`endif
    end else begin
      r_state <= w_next;

      if (w_load_gap)
        r_gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (r_state == ST_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - 1'b1;

      if (r_state == ST_GAP && r_gap_cnt == '0) r_daddr <= w_map;

      r_to_cnt <= (r_state == ST_WAIT) ? r_to_cnt + 1'b1 : '0;

`ifdef XADC_SCAN_AVG_EN
      if (w_capture) begin
        r_acc <= r_acc + {2'b00, do_in[15:4]};
        r_rep <= r_rep + 1'b1;
      end else if (w_store || w_timeout) begin
        r_acc <= '0;
        r_rep <= '0;
      end
`else
      if (w_capture) r_sample <= do_in[15:4];
`endif

      if (w_store) begin
        r_entry[r_ch] <= w_result;
        r_valid       <= r_valid | w_ch_mask;
      end

      if (w_advance) r_ch <= (r_ch == LAST_CH) ? 4'd0 : r_ch + 4'd1;
      if (w_timeout) r_err <= 1'b1;
      r_scan_done <= w_advance && (r_ch == LAST_CH);

      // Registered read port; a same-cycle write is seen one cycle later.
      r_rd_data <= (rd_ch <= LAST_CH) ? r_entry[rd_ch] : 12'h000;
    end
  end

endmodule

// File: tb/tb_xadc_channel_scanner.sv
// Directed bench for xadc_channel_scanner with a simple DRP responder (drdy 3 cycles after den).
module tb_xadc_channel_scanner;

  localparam int GAP = 4;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [6:0]  daddr_out;
  logic        den_out;
  logic [15:0] do_in;
  logic        drdy_in;
  logic [3:0]  rd_ch;
  logic [11:0] rd_data;
  logic [12:0] ch_valid;
  logic        scan_done;
  logic        drp_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int drp_on = 1;
  int drp_mode = 0;
  int drp_withhold = -1;
  int avg_k = 0;
  int den_cnt = 0;
  int done_cnt = 0;
  logic late_req = 1'b0;
  logic late_seen = 1'b0;
  logic [6:0] m_addr;
  logic [3:0] m_ch;
  int n;
  int base;

  always #5 clk = ~clk;

  xadc_channel_scanner #(.NUM_CH(13), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .daddr_out(daddr_out), .den_out(den_out),
    .do_in(do_in), .drdy_in(drdy_in), .rd_ch(rd_ch), .rd_data(rd_data), .ch_valid(ch_valid),
    .scan_done(scan_done), .drp_err(drp_err), .state_dbg(state_dbg)
  );

  always @(posedge clk) begin
    if (den_out) den_cnt <= den_cnt + 1;
    if (scan_done) done_cnt <= done_cnt + 1;
  end

  // DRP responder: drdy_in sampled by the DUT 3 cycles after the den_out cycle.
  initial begin
    drdy_in = 1'b0;
    do_in   = 16'h0000;
    forever begin
      @(negedge clk);
      if (late_req != late_seen) begin
        late_seen = late_req;
        drdy_in = 1'b1;
        do_in   = 16'hFFF0;
        @(negedge clk);
        drdy_in = 1'b0;
        do_in   = 16'h0000;
      end else if (drp_on != 0 && den_out && !rst) begin
        m_addr = daddr_out;
        if (int'(m_addr) != drp_withhold) begin
          repeat (2) @(negedge clk);
          case (drp_mode)
            0: do_in = 16'h8000;
            1: begin
              m_ch  = (m_addr == 7'h03) ? 4'd0 : 4'(m_addr - 7'h0F);
              do_in = {m_ch, 12'h000};
            end
            default: begin
              do_in = 16'h1000 + 16'(avg_k << 4);
              avg_k++;
            end
          endcase
          drdy_in = 1'b1;
          @(negedge clk);
          drdy_in = 1'b0;
          do_in   = 16'h0000;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_den(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (den_out) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_den_addr(input logic [6:0] a, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (den_out && daddr_out == a) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    scan_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    scan_en = 1'b0;
    rd_ch = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_den", den_out, 1'b0);
    chk("rst_daddr", daddr_out, 7'h00);
    chk("rst_valid", ch_valid, 13'h0000);
    chk("rst_err", drp_err, 1'b0);
    chk("rst_done", scan_done, 1'b0);
    chk("rst_rd_data", rd_data, 12'h000);

`ifdef XADC_SCAN_AVG_EN
    drp_mode = 2;
    @(negedge clk);
    scan_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_den(n);
      chk("avg_den_found", (n > 0), 1'b1);
      chk("avg_daddr", daddr_out, 7'h03);
    end
    @(negedge clk);
    scan_en = 1'b0;
    rd_ch = 4'd0;
    repeat (20) @(posedge clk);
    #1;
    chk("avg_rd_data", rd_data, 12'h101);
    chk("avg_valid", ch_valid, 13'h0001);
`else
    // First read: den GAP cycles after scan_en is sampled; next read 4 + GAP cycles later.
    drp_mode = 0;
    @(negedge clk);
    scan_en = 1'b1;
    @(posedge clk);
    wait_den(n);
    chk("first_den_delay", n, GAP);
    chk("first_daddr", daddr_out, 7'h03);
    wait_den(n);
    chk("second_den_delay", n, 4 + GAP);
    chk("second_daddr", daddr_out, 7'h10);
    @(negedge clk);
    rd_ch = 4'd0;
    @(posedge clk); #1;
    chk("ch0_data", rd_data, 12'h800);
    scan_en = 1'b0;
    repeat (30) @(posedge clk);

    // Full pass with channel-tagged data.
    do_reset();
    drp_mode = 1;
    base = done_cnt;
    scan_en = 1'b1;
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (scan_done) begin
        n = i;
        break;
      end
    end
    chk("pass_done_seen", (n > 0), 1'b1);
    chk("pass_valid", ch_valid, 13'h1FFF);
    @(negedge clk);
    scan_en = 1'b0;
    rd_ch = 4'd5;
    @(posedge clk); #1;
    chk("pass_rd5", rd_data, 12'h500);
    @(negedge clk);
    rd_ch = 4'd12;
    @(posedge clk); #1;
    chk("pass_rd12", rd_data, 12'hC00);
    @(negedge clk);
    rd_ch = 4'd13;
    @(posedge clk); #1;
    chk("pass_rd13_zero", rd_data, 12'h000);
    repeat (40) @(posedge clk);
    #1;
    chk("pass_done_count", done_cnt - base, 1);

    // Timeout on ch 3: den cycle plus TO waiting cycles before drp_err registers.
    do_reset();
    drp_withhold = 'h12;
    scan_en = 1'b1;
    wait_den_addr(7'h12, n);
    chk("to_den_seen", (n > 0), 1'b1);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (drp_err) begin
        n = i;
        break;
      end
    end
    chk("to_err_delay", n, TO + 1);
    wait_den(n);
    chk("to_next_daddr", daddr_out, 7'h13);
    chk("to_valid", ch_valid, 13'h0007);
    @(negedge clk);
    scan_en = 1'b0;
    drp_withhold = -1;
    repeat (40) @(posedge clk);

    // scan_en dropped while ch 2 is in flight.
    do_reset();
    scan_en = 1'b1;
    wait_den_addr(7'h11, n);
    @(posedge clk); #1;
    scan_en = 1'b0;
    base = den_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("stop_no_den", den_cnt - base, 0);
    chk("stop_state_idle", state_dbg, 3'd0);
    chk("stop_valid", ch_valid, 13'h0007);
    @(negedge clk);
    rd_ch = 4'd2;
    @(posedge clk); #1;
    chk("stop_rd2", rd_data, 12'h200);

    // Reset mid-read, followed by a stale drdy.
    do_reset();
    drp_on = 0;
    rd_ch = 4'd0;
    scan_en = 1'b1;
    wait_den_addr(7'h03, n);
    chk("rr_den_seen", (n > 0), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    scan_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    late_req = ~late_req;
    repeat (5) @(posedge clk);
    #1;
    chk("rr_state", state_dbg, 3'd0);
    chk("rr_den", den_out, 1'b0);
    chk("rr_daddr", daddr_out, 7'h00);
    chk("rr_valid", ch_valid, 13'h0000);
    chk("rr_err", drp_err, 1'b0);
    chk("rr_entry0", rd_data, 12'h000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
